axis_aximm_burst_wr: RTL and testbench



---
 rtl/axis_aximm_pkg.sv | 22 ++
 rtl/axis_aximm_sync_fifo.sv | 58 +++++
 rtl/axis_aximm_burst_wr.sv | 244 ++++++++++++++++++++++++
 tb/tb_axis_aximm_burst_wr.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_aximm_pkg.sv
// Shared types and constants for the AXI-Stream to AXI4 burst writer.
package axis_aximm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI AxSIZE encoding for a full-width beat of data_w bits.
  function automatic logic [2:0] awsize_of(input int unsigned data_w);
    int unsigned v;
    v = $clog2(data_w / 8);
    return v[2:0];
  endfunction

endpackage

// File: rtl/axis_aximm_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
module axis_aximm_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axis_aximm_burst_wr.sv
// Buffers one AXI-Stream packet and writes it as AXI4 INCR bursts into a ring.
module axis_aximm_burst_wr
  import axis_aximm_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned BURST_LEN       = 16,
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                INIT_AXI_TXN,
  input  logic [ADDR_W-1:0]   CFG_BASE_ADDR,
  input  logic [ADDR_W-1:0]   CFG_RING_BYTES,
  output logic                TXN_DONE,
  output logic                ERROR,
  output logic                BUSY,
  output logic [31:0]         BEAT_COUNT,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  input  logic                S_AXIS_TLAST,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [7:0]          M_AXI_AWLEN,
  output logic [2:0]          M_AXI_AWSIZE,
  output logic [1:0]          M_AXI_AWBURST,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WLAST,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY
);

  localparam int unsigned BEAT_BYTES = DATA_W / 8;
  localparam int unsigned BB         = BURST_LEN * BEAT_BYTES;
  localparam int unsigned DCW        = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned QCW        = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_W-1:0] BB_MASK = ADDR_W'(BB - 1);

  state_t state, state_next;

  logic              init_q, init_rise, start;
  logic [ADDR_W-1:0] cfg_base, cfg_ring, ring_end;
  logic              cfg_ok;

  logic [DATA_W-1:0] d_head;
  logic [DCW-1:0]    d_count;
  logic              d_full, d_empty, d_push;
  logic [7:0]        q_head;
  logic [QCW-1:0]    q_count;
  logic              q_full, q_empty, q_pop;

  logic [DCW-1:0]    pending, issue_beats;
  logic [QCW-1:0]    outstanding;
  logic              awvalid;
  logic [ADDR_W-1:0] awaddr, burst_bytes, addr_inc, addr_next;
  logic [7:0]        awlen, issue_len, wbeat;
  logic              burst_ready, can_issue;
  logic              aw_hs, w_hs, b_hs, wvalid, wlast;
  logic              error_q;
  logic [31:0]       beat_count;
  logic              tready, bready, busy, txn_done;

  assign init_rise = INIT_AXI_TXN && !init_q;
  assign start     = init_rise && ((state == ST_IDLE) || (state == ST_DONE));
  assign cfg_ok    = (cfg_ring != '0) && ((cfg_ring & BB_MASK) == '0) &&
                     ((cfg_base & BB_MASK) == '0);

  assign d_push = S_AXIS_TVALID && tready;
  assign aw_hs  = awvalid && M_AXI_AWREADY;
  assign wvalid = !q_empty && !d_empty;
  assign wlast  = wvalid && (wbeat == q_head);
  assign w_hs   = wvalid && M_AXI_WREADY;
  assign q_pop  = w_hs && wlast;
  assign b_hs   = M_AXI_BVALID && bready;

  // Bursts are carved out of buffered beats at AW-issue time, so `pending`
  // drops when AWVALID is raised, not when the beats actually leave the FIFO.
  assign burst_ready = (pending >= DCW'(BURST_LEN)) ||
                       ((state == ST_DRAIN) && (pending != '0));
  assign can_issue   = ((state == ST_RUN) || (state == ST_DRAIN)) && !awvalid &&
                       burst_ready && !q_full &&
                       (outstanding < QCW'(MAX_OUTSTANDING));
  assign issue_beats = (pending >= DCW'(BURST_LEN)) ? DCW'(BURST_LEN) : pending;
  assign issue_len   = 8'(issue_beats - 1'b1);

  assign burst_bytes = (ADDR_W'(awlen) + 1'b1) * ADDR_W'(BEAT_BYTES);
  assign addr_inc    = awaddr + burst_bytes;
  assign addr_next   = (addr_inc == ring_end) ? cfg_base : addr_inc;

  axis_aximm_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .push      (d_push),
    .push_data (S_AXIS_TDATA),
    .pop       (w_hs),
    .pop_data  (d_head),
    .count     (d_count),
    .full      (d_full),
    .empty     (d_empty)
  );

  axis_aximm_sync_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_len_queue (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .push      (aw_hs),
    .push_data (awlen),
    .pop       (q_pop),
    .pop_data  (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state;
    tready     = 1'b0;
    bready     = 1'b0;
    busy       = 1'b0;
    txn_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_rise) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        busy       = 1'b1;
        state_next = cfg_ok ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        busy   = 1'b1;
        bready = 1'b1;
        tready = !d_full;
        if (S_AXIS_TVALID && !d_full && S_AXIS_TLAST) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy   = 1'b1;
        bready = 1'b1;
        if ((d_count == '0) && (pending == '0) && (q_count == '0) &&
            (outstanding == '0) && !awvalid)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        txn_done = 1'b1;
        if (init_rise) state_next = ST_CHECK;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // INIT edge detect and configuration capture.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_q   <= 1'b0;
      cfg_base <= '0;
      cfg_ring <= '0;
      ring_end <= '0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (start) begin
        cfg_base <= CFG_BASE_ADDR;
        cfg_ring <= CFG_RING_BYTES;
        ring_end <= CFG_BASE_ADDR + CFG_RING_BYTES;
      end
    end
  end

  // AW channel: burst carving, address walk with ring wrap, in-flight count.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pending     <= '0;
      outstanding <= '0;
      awvalid     <= 1'b0;
      awaddr      <= '0;
      awlen       <= '0;
    end else if (start) begin
      pending     <= '0;
      outstanding <= '0;
    end else begin
      pending <= pending + DCW'(d_push) - (can_issue ? issue_beats : '0);
      if (can_issue) begin
        awvalid <= 1'b1;
        awlen   <= issue_len;
      end else if (aw_hs) begin
        awvalid <= 1'b0;
      end
      if (state == ST_CHECK) awaddr <= cfg_base;
      else if (aw_hs)        awaddr <= addr_next;
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // W beat position within the head burst, sticky error and beat counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wbeat      <= '0;
      error_q    <= 1'b0;
      beat_count <= '0;
    end else begin
      if (w_hs) wbeat <= wlast ? 8'd0 : wbeat + 1'b1;
      if (start) begin
        error_q    <= 1'b0;
        beat_count <= '0;
      end else begin
        if ((state == ST_CHECK) && !cfg_ok)                 error_q <= 1'b1;
        else if (b_hs && (M_AXI_BRESP != AXI_RESP_OKAY))    error_q <= 1'b1;
        if (w_hs && (beat_count != '1)) beat_count <= beat_count + 1'b1;
      end
    end
  end

  assign TXN_DONE      = txn_done;
  assign ERROR         = error_q;
  assign BUSY          = busy;
  assign BEAT_COUNT    = beat_count;
  assign S_AXIS_TREADY = tready;
  assign M_AXI_AWADDR  = awaddr;
  assign M_AXI_AWLEN   = awlen;
  assign M_AXI_AWSIZE  = awsize_of(DATA_W);
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_WDATA   = wvalid ? d_head : '0;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = wlast;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = bready;

endmodule

// File: tb/tb_axis_aximm_burst_wr.sv
// Directed bench for axis_aximm_burst_wr with a small AXI4 write slave model.
module tb_axis_aximm_burst_wr;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        INIT_AXI_TXN;
  logic [31:0] CFG_BASE_ADDR, CFG_RING_BYTES;
  logic        TXN_DONE, ERROR, BUSY;
  logic [31:0] BEAT_COUNT;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;

  always #5 ACLK = ~ACLK;

  axis_aximm_burst_wr #(
    .DATA_W(32), .ADDR_W(32), .BURST_LEN(16), .FIFO_DEPTH(64), .MAX_OUTSTANDING(2)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .INIT_AXI_TXN(INIT_AXI_TXN),
    .CFG_BASE_ADDR(CFG_BASE_ADDR), .CFG_RING_BYTES(CFG_RING_BYTES),
    .TXN_DONE(TXN_DONE), .ERROR(ERROR), .BUSY(BUSY), .BEAT_COUNT(BEAT_COUNT),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
  );

  int vectors = 0;
  int miscompares = 0;

  // Slave model state.
  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
  typedef struct { int unsigned due; logic [1:0] resp; } b_t;
  logic [31:0] mem [int unsigned];
  logic [31:0] aw_log_addr [$];
  logic [7:0]  aw_log_len [$];
  aw_t         awq [$];
  b_t          bq [$];
  int unsigned cyc = 0, wbeat_v = 0, bcount = 0, outs = 0, max_outs = 0, proto_err = 0;
  int unsigned err_idx = 0, bdelay = 0;
  logic        s_aw = 0, s_w = 0, s_b = 0, s_wlast = 0;
  logic [31:0] s_awaddr = 0, s_wdata = 0;
  logic [7:0]  s_awlen = 0;
  logic [3:0]  s_wstrb = 0;

  // Handshakes snapshotted at one negedge completed at the posedge that followed it.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      awq.delete(); bq.delete();
      wbeat_v = 0; outs = 0;
      M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
      s_aw = 0; s_w = 0; s_b = 0;
    end else begin
      cyc++;
      if (s_aw) begin
        awq.push_back('{s_awaddr, s_awlen});
        aw_log_addr.push_back(s_awaddr);
        aw_log_len.push_back(s_awlen);
        outs++;
        if (outs > max_outs) max_outs = outs;
      end
      if (s_w) begin
        if (awq.size() == 0) proto_err++;
        else begin
          mem[awq[0].addr + 4 * wbeat_v] = s_wdata;
          if (s_wstrb != 4'hF) proto_err++;
          if (s_wlast != (wbeat_v == int'(awq[0].len))) proto_err++;
          if (s_wlast) begin
            void'(awq.pop_front());
            wbeat_v = 0;
            bcount++;
            bq.push_back('{cyc + bdelay, (bcount == err_idx) ? 2'b10 : 2'b00});
          end else wbeat_v++;
        end
      end
      if (s_b) begin
        void'(bq.pop_front());
        outs--;
      end
      M_AXI_BVALID = (bq.size() > 0) && (bq[0].due <= cyc);
      M_AXI_BRESP  = M_AXI_BVALID ? bq[0].resp : 2'b00;
      s_aw = M_AXI_AWVALID && M_AXI_AWREADY;
      s_awaddr = M_AXI_AWADDR; s_awlen = M_AXI_AWLEN;
      s_w = M_AXI_WVALID && M_AXI_WREADY;
      s_wdata = M_AXI_WDATA; s_wlast = M_AXI_WLAST; s_wstrb = M_AXI_WSTRB;
      s_b = M_AXI_BVALID && M_AXI_BREADY;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] base, input logic [31:0] ring);
    CFG_BASE_ADDR = base; CFG_RING_BYTES = ring; INIT_AXI_TXN = 1'b1;
    @(negedge ACLK);
    INIT_AXI_TXN = 1'b0;
  endtask

  task automatic send(input int n, input logic [31:0] seed);
    int guard;
    for (int i = 0; i < n; i++) begin
      S_AXIS_TDATA = seed + 32'(i); S_AXIS_TLAST = (i == n - 1); S_AXIS_TVALID = 1'b1;
      guard = 0;
      while (!S_AXIS_TREADY && guard < 1000) begin @(negedge ACLK); guard++; end
      if (guard >= 1000) begin
        check("stream_accept_timeout", 64'(i), 64'(n));
        break;
      end
      @(negedge ACLK);
    end
    S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int waited);
    waited = 0;
    while (!TXN_DONE && waited < budget) begin @(negedge ACLK); waited++; end
    @(negedge ACLK);
  endtask

  // Counts ring words that do not hold seed+first+k for k in 0..n-1.
  function automatic int mem_bad(input logic [31:0] addr, input int n,
                                 input logic [31:0] seed, input int first);
    int bad = 0;
    for (int k = 0; k < n; k++) begin
      int unsigned a = addr + 4 * k;
      if (!mem.exists(a)) bad++;
      else if (mem[a] !== seed + 32'(first + k)) bad++;
    end
    return bad;
  endfunction

  initial begin
    int w, idx, bad;
    ARESETN = 1'b0; INIT_AXI_TXN = 1'b0; CFG_BASE_ADDR = '0; CFG_RING_BYTES = '0;
    S_AXIS_TDATA = '0; S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
    M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
    repeat (3) @(negedge ACLK);
    check("rst_status", {TXN_DONE, ERROR, BUSY, S_AXIS_TREADY}, 0);
    check("rst_axi", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, M_AXI_AWADDR, M_AXI_AWLEN}, 0);
    check("rst_beat_count", BEAT_COUNT, 0);
    check("awsize_awburst", {M_AXI_AWSIZE, M_AXI_AWBURST}, {3'd2, 2'b01});
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // 1: 40 beats into a 1 KB ring -> 16 + 16 + 8.
    idx = aw_log_addr.size();
    start(32'h1000, 32'h400);
    check("t1_busy", BUSY, 1);
    send(40, 32'hA000_0000);
    wait_done(2000, w);
    check("t1_done", {TXN_DONE, BUSY, ERROR}, 3'b100);
    check("t1_aw_count", aw_log_addr.size() - idx, 3);
    check("t1_aw0", {aw_log_addr[idx], aw_log_len[idx]}, {32'h1000, 8'd15});
    check("t1_aw1", {aw_log_addr[idx+1], aw_log_len[idx+1]}, {32'h1040, 8'd15});
    check("t1_aw2", {aw_log_addr[idx+2], aw_log_len[idx+2]}, {32'h1080, 8'd7});
    check("t1_beat_count", BEAT_COUNT, 40);
    check("t1_mem", mem_bad(32'h1000, 40, 32'hA000_0000, 0), 0);

    // 2: 128-byte ring wraps after two bursts.
    idx = aw_log_addr.size();
    start(32'h1000, 32'h80);
    send(64, 32'hB000_0000);
    wait_done(2000, w);
    check("t2_done", {TXN_DONE, ERROR}, 2'b10);
    check("t2_aw_count", aw_log_addr.size() - idx, 4);
    check("t2_aw_addrs", {aw_log_addr[idx], aw_log_addr[idx+1], aw_log_addr[idx+2], aw_log_addr[idx+3]},
          {32'h1000, 32'h1040, 32'h1000, 32'h1040});
    check("t2_mem", mem_bad(32'h1000, 32, 32'hB000_0000, 32), 0);

    // 3: slow B responses throttle AW issue at two in flight.
    bdelay = 50; max_outs = 0;
    idx = aw_log_addr.size();
    start(32'h1000, 32'h400);
    send(96, 32'hC000_0000);
    wait_done(3000, w);
    bdelay = 0;
    check("t3_done", {TXN_DONE, ERROR}, 2'b10);
    check("t3_max_outstanding", max_outs, 2);
    check("t3_aw_count", aw_log_addr.size() - idx, 6);
    check("t3_last_aw", {aw_log_addr[idx+5], aw_log_len[idx+5]}, {32'h1140, 8'd15});
    check("t3_beat_count", BEAT_COUNT, 96);
    check("t3_mem", mem_bad(32'h1000, 96, 32'hC000_0000, 0), 0);

    // 4: SLVERR on the second B is sticky but does not stop the transfer.
    err_idx = bcount + 2;
    idx = aw_log_addr.size();
    start(32'h1000, 32'h400);
    send(48, 32'hD000_0000);
    wait_done(2000, w);
    check("t4_done_error", {TXN_DONE, ERROR}, 2'b11);
    check("t4_aw_count", aw_log_addr.size() - idx, 3);
    check("t4_beat_count", BEAT_COUNT, 48);
    check("t4_mem", mem_bad(32'h1000, 48, 32'hD000_0000, 0), 0);

    // 5: misaligned base is rejected without AXI traffic.
    idx = aw_log_addr.size();
    start(32'h1004, 32'h400);
    wait_done(20, w);
    check("t5_latency_ok", (w <= 2), 1);
    check("t5_done_error", {TXN_DONE, ERROR, BUSY}, 3'b110);
    check("t5_no_aw", aw_log_addr.size() - idx, 0);
    check("t5_beat_count", BEAT_COUNT, 0);

    // 6: reset in the middle of a burst, then a fresh short packet.
    start(32'h1000, 32'h400);
    send(20, 32'hE000_0000);
    check("t6_midburst", M_AXI_WVALID, 1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    check("t6_rst_status", {TXN_DONE, ERROR, BUSY, S_AXIS_TREADY, BEAT_COUNT}, 0);
    check("t6_rst_axi", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, M_AXI_AWADDR, M_AXI_AWLEN}, 0);
    check("t6_rst_wdata", M_AXI_WDATA, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    idx = aw_log_addr.size();
    start(32'h2000, 32'h400);
    send(5, 32'hF000_0000);
    wait_done(2000, w);
    check("t6_done", {TXN_DONE, ERROR}, 2'b10);
    check("t6_aw_count", aw_log_addr.size() - idx, 1);
    check("t6_aw0", {aw_log_addr[idx], aw_log_len[idx]}, {32'h2000, 8'd4});
    check("t6_beat_count", BEAT_COUNT, 5);
    check("t6_mem", mem_bad(32'h2000, 5, 32'hF000_0000, 0), 0);
    check("w_protocol_errors", proto_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
